// File: rtl/frame_stream_pkg.sv
// ---------------------------------------------------------------------------
// frame_stream_pkg
//
// Purpose:
//   Shared definitions for the frame stream sequencer: the FSM state
//   encoding and the default widths and timeout used by frame_stream_ctrl.
//
// Contents:
//   state_t          - 2-bit state register type
//   ST_IDLE          - not streaming, counter untouched
//   ST_ARM           - waiting for the vsync rising edge to align
//   ST_STREAM        - streaming pixels, counter follows accepted pixels
//   FCNT_W_DEF       - default width of the completed-frame counter
//   UCNT_W_DEF       - default width of the underrun counter
//   TIMEOUT_DEF      - default stall limit when FRAME_STREAM_TIMEOUT_EN is set
// ---------------------------------------------------------------------------
package frame_stream_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ARM    = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

  localparam int FCNT_W_DEF  = 16;
  localparam int UCNT_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 1024;

endpackage : frame_stream_pkg

// File: rtl/frame_stream_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Purpose:
//   Up-counter that sticks at all-ones instead of wrapping. Used for the
//   underrun statistic and, when the stall timeout is built in, for the
//   consecutive-stall counter.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, clears the count
//   clr      in   synchronous clear, has priority over inc
//   inc      in   count up by one unless already saturated
//   count    out  W-bit current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/frame_stream_ctrl.sv
// ---------------------------------------------------------------------------
// frame_stream_ctrl
//
// Purpose:
//   Sequencer for the pixel frame counter. A software start arms the block,
//   a rising edge on vsync_in aligns the frame counter to (0,0), and from
//   then on the counter advances once per pixel accepted on the
//   source -> sink valid/ready stream. Streaming stops only on a frame
//   boundary (stop request or single-frame mode). Completed frames and
//   underrun cycles are counted; a vsync edge that arrives away from the
//   frame start re-aligns the counter and sets the sticky sync_err flag.
//
// Build option:
//   FRAME_STREAM_TIMEOUT_EN - when defined, TIMEOUT consecutive STREAM cycles
//   without a transfer abort to IDLE, set sync_err and pulse fc_sync_clr.
//   When undefined the stream may stall indefinitely and TIMEOUT is unused.
//
// Ports:
//   clk             in   system clock
//   reset_n         in   asynchronous active-low reset
//   start           in   single-cycle request to arm streaming
//   stop            in   single-cycle request to stop at the next frame end
//   single          in   level, 1 = stop automatically after one frame
//   vsync_in        in   external vsync level, synchronous to clk
//   fc_frame_start  in   frame counter is at (0,0)
//   fc_frame_end    in   frame counter is at its last pixel
//   fc_inc          out  advance frame counter
//   fc_sync_clr     out  clear frame counter to (0,0)
//   src_valid       in   source pixel valid
//   src_ready       out  source pixel accepted
//   dst_valid       out  sink pixel valid
//   dst_ready       in   sink ready
//   busy            out  state is not IDLE
//   frame_cnt       out  completed frames since reset (wraps)
//   underrun_cnt    out  STREAM cycles with dst_ready && !src_valid (saturates)
//   sync_err        out  sticky vsync misalignment / timeout flag
// ---------------------------------------------------------------------------
module frame_stream_ctrl
  import frame_stream_pkg::*;
#(
  parameter int FCNT_W  = FCNT_W_DEF,
  parameter int UCNT_W  = UCNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic              vsync_in,
  input  logic              fc_frame_start,
  input  logic              fc_frame_end,
  output logic              fc_inc,
  output logic              fc_sync_clr,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              sync_err
);

  // state  | meaning
  // IDLE   | no streaming, all handshake outputs low
  // ARM    | armed by start, waiting for a vsync rising edge to align
  // STREAM | pixels pass through, counter advances per accepted pixel

  state_t            state;
  state_t            state_nxt;
  logic              vs_q;
  logic              vs_edge;
  logic              stop_pending;
  logic              stop_pending_nxt;
  logic              sync_err_nxt;
  logic [FCNT_W-1:0] frame_cnt_nxt;

  logic in_stream;
  logic resync;
  logic xfer;
  logic underrun;
  logic timeout_hit;

  // Rising edge is seen in the same cycle vsync_in goes high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vsync_in;
    end
  end

  assign vs_edge   = vsync_in && !vs_q;
  assign in_stream = (state == ST_STREAM);

  // A misaligned edge steals the cycle for the counter clear, so no pixel
  // may be accepted in it.
  assign resync    = in_stream && vs_edge && !fc_frame_start;
  assign xfer      = in_stream && src_valid && dst_ready && !resync;
  assign underrun  = in_stream && dst_ready && !src_valid;

  sat_counter #(
    .W (UCNT_W)
  ) u_underrun (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (underrun),
    .count   (underrun_cnt)
  );

`ifdef FRAME_STREAM_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // stall_cnt holds the stall cycles already seen; the TIMEOUT-th
  // consecutive stall cycle is the one that aborts.
  sat_counter #(
    .W (STALL_W)
  ) u_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_stream || xfer),
    .inc     (in_stream && !xfer),
    .count   (stall_cnt)
  );

  assign timeout_hit = in_stream && !xfer && (stall_cnt == STALL_LAST);
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Handshake and counter control. The sink-side valid is also dropped
  // during a resync cycle so that neither side sees a transfer the other
  // did not take part in.
  always_comb begin
    fc_inc      = 1'b0;
    fc_sync_clr = 1'b0;
    src_ready   = 1'b0;
    dst_valid   = 1'b0;
    case (state)
      ST_ARM: begin
        fc_sync_clr = vs_edge && !stop;
      end
      ST_STREAM: begin
        fc_inc      = xfer;
        src_ready   = dst_ready && !resync;
        dst_valid   = src_valid && !resync;
        fc_sync_clr = resync || timeout_hit;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_nxt        = state;
    stop_pending_nxt = stop_pending;
    sync_err_nxt     = sync_err;
    frame_cnt_nxt    = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt        = ST_ARM;
          stop_pending_nxt = 1'b0;
          sync_err_nxt     = 1'b0;
        end
      end
      ST_ARM: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (vs_edge) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (resync || timeout_hit) begin
          sync_err_nxt = 1'b1;
        end
        if (xfer && fc_frame_end) begin
          frame_cnt_nxt = frame_cnt + 1'b1;
          if (stop_pending || single || stop) begin
            state_nxt = ST_IDLE;
          end
        end else if (stop) begin
          stop_pending_nxt = 1'b1;
        end
        if (timeout_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      stop_pending <= 1'b0;
      sync_err     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      stop_pending <= stop_pending_nxt;
      sync_err     <= sync_err_nxt;
      frame_cnt    <= frame_cnt_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule : frame_stream_ctrl
